// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 defaults), frame totals and the
// per-axis phase enumeration used by both sync-generator axes.
package vga_timing_pkg;

  localparam int CW = 10;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FRONT_DEF  = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BACK_DEF   = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FRONT_DEF  = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BACK_DEF   = 33;

  localparam int H_TOTAL = H_ACTIVE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL = V_ACTIVE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_e;

  function automatic int axis_total(input int active, input int front,
                                    input int sync, input int back);
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_axis_timer.sv
// One timing axis: position counter, ACTIVE/FRONT/SYNC/BACK phase FSM with
// registered sync/active outputs, and a same-cycle wrap flag for chaining.
module vga_axis_timer
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_DEF,
  parameter int FRONT  = H_FRONT_DEF,
  parameter int SYNC   = H_SYNC_DEF,
  parameter int BACK   = H_BACK_DEF
) (
  input  logic          i_CLK,
  input  logic          i_RST_N,
  input  logic          i_step,
  output logic [CW-1:0] o_pos,
  output logic [1:0]    o_phase,
  output logic          o_sync_n,
  output logic          o_active_nxt,
  output logic          o_wrap
);

  localparam int TOTAL = axis_total(ACTIVE, FRONT, SYNC, BACK);
  localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACT_LAST   = CW'(ACTIVE - 1);
  localparam logic [CW-1:0] FRONT_LAST = CW'(ACTIVE + FRONT - 1);
  localparam logic [CW-1:0] SYNC_LAST  = CW'(ACTIVE + FRONT + SYNC - 1);

  phase_e phase;
  logic   active;

  assign o_phase = phase;
  assign o_wrap  = i_step && (o_pos == LAST);

  // Lets the parent register a combined display enable aligned with o_pos.
  always_comb begin
    o_active_nxt = active;
    if (i_step) begin
      o_active_nxt = ((phase == PH_ACTIVE) && (o_pos != ACT_LAST)) ||
                     ((phase == PH_BACK) && (o_pos == LAST));
    end
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      o_pos    <= LAST;
      phase    <= PH_BACK;
      o_sync_n <= 1'b1;
      active   <= 1'b0;
    end else if (i_step) begin
      o_pos <= o_wrap ? '0 : o_pos + CW'(1);
      case (phase)
        PH_ACTIVE: if (o_pos == ACT_LAST) begin
          phase  <= PH_FRONT;
          active <= 1'b0;
        end
        PH_FRONT: if (o_pos == FRONT_LAST) begin
          phase    <= PH_SYNC;
          o_sync_n <= 1'b0;
        end
        PH_SYNC: if (o_pos == SYNC_LAST) begin
          phase    <= PH_BACK;
          o_sync_n <= 1'b1;
        end
        PH_BACK: if (o_pos == LAST) begin
          phase  <= PH_ACTIVE;
          active <= 1'b1;
        end
        default: phase <= PH_BACK;
      endcase
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: horizontal axis steps on i_en, vertical axis steps on
// the horizontal wrap; all outputs registered and aligned to (x,y).
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FRONT  = H_FRONT_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BACK   = H_BACK_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FRONT  = V_FRONT_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BACK   = V_BACK_DEF
) (
  input  logic       i_CLK,
  input  logic       i_RST_N,
  input  logic       i_en,
  output logic [9:0] o_x_pos,
  output logic [9:0] o_y_pos,
  output logic       o_hSync,
  output logic       o_vSync,
  output logic       o_display_en,
  output logic       o_line_start,
  output logic       o_frame_start
);

  logic [1:0] h_phase, v_phase;
  logic       h_act_nxt, v_act_nxt;
  logic       h_wrap, v_wrap;

  vga_axis_timer #(
    .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
  ) u_h_axis (
    .i_CLK        (i_CLK),
    .i_RST_N      (i_RST_N),
    .i_step       (i_en),
    .o_pos        (o_x_pos),
    .o_phase      (h_phase),
    .o_sync_n     (o_hSync),
    .o_active_nxt (h_act_nxt),
    .o_wrap       (h_wrap)
  );

  vga_axis_timer #(
    .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
  ) u_v_axis (
    .i_CLK        (i_CLK),
    .i_RST_N      (i_RST_N),
    .i_step       (h_wrap),
    .o_pos        (o_y_pos),
    .o_phase      (v_phase),
    .o_sync_n     (o_vSync),
    .o_active_nxt (v_act_nxt),
    .o_wrap       (v_wrap)
  );

  // v_wrap already implies h_wrap because the vertical axis only steps then.
  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      o_display_en  <= 1'b0;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      o_display_en  <= h_act_nxt && v_act_nxt;
      o_line_start  <= h_wrap;
      o_frame_start <= v_wrap;
    end
  end

  a_h_phase_sync : assert property (@(posedge i_CLK) disable iff (!i_RST_N)
    (h_phase == PH_SYNC) == !o_hSync);
  a_v_phase_sync : assert property (@(posedge i_CLK) disable iff (!i_RST_N)
    (v_phase == PH_SYNC) == !o_vSync);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default-timing instance for line-level behaviour
// and a reduced-timing instance so whole frames fit in a short run.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_n;
  logic [1:0] en;
  logic [9:0] x_pos [2];
  logic [9:0] y_pos [2];
  logic [1:0] hs, vs, de, ls, fs;

  vga_sync_gen u_dut0 (
    .i_CLK(clk), .i_RST_N(rst_n[0]), .i_en(en[0]),
    .o_x_pos(x_pos[0]), .o_y_pos(y_pos[0]), .o_hSync(hs[0]), .o_vSync(vs[0]),
    .o_display_en(de[0]), .o_line_start(ls[0]), .o_frame_start(fs[0])
  );

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
  ) u_dut1 (
    .i_CLK(clk), .i_RST_N(rst_n[1]), .i_en(en[1]),
    .o_x_pos(x_pos[1]), .o_y_pos(y_pos[1]), .o_hSync(hs[1]), .o_vSync(vs[1]),
    .o_display_en(de[1]), .o_line_start(ls[1]), .o_frame_start(fs[1])
  );

  // Timing per instance, and hand-computed period/width figures.
  int p_ha [2] = '{640, 8};
  int p_hf [2] = '{16, 2};
  int p_hs [2] = '{96, 3};
  int p_hb [2] = '{48, 2};
  int p_va [2] = '{480, 6};
  int p_vf [2] = '{10, 1};
  int p_vs [2] = '{2, 2};
  int p_vb [2] = '{33, 2};

  int exp_line   [2] = '{800, 15};
  int exp_de     [2] = '{640, 8};
  int exp_hlow   [2] = '{96, 3};
  int exp_hstart [2] = '{656, 10};
  int exp_frame  [2] = '{420000, 165};
  int exp_vlow   [2] = '{1600, 30};
  int exp_vstart [2] = '{490, 7};

  int n_checks = 0;
  int n_fail   = 0;

  function automatic int h_tot(input int i);
    return p_ha[i] + p_hf[i] + p_hs[i] + p_hb[i];
  endfunction

  function automatic int v_tot(input int i);
    return p_va[i] + p_vf[i] + p_vs[i] + p_vb[i];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position counts plus pulse flags, from the timing rules.
  int mx [2], my [2];
  bit mls [2], mfs [2], madv [2], mrst [2], mvalid [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      madv[i] = 1'b0;
      mrst[i] = 1'b0;
      if (!rst_n[i]) begin
        mx[i] = h_tot(i) - 1;
        my[i] = v_tot(i) - 1;
        mls[i] = 1'b0;
        mfs[i] = 1'b0;
        mrst[i] = 1'b1;
        mvalid[i] = 1'b1;
      end else if (en[i]) begin
        madv[i] = 1'b1;
        mls[i] = (mx[i] == h_tot(i) - 1);
        mfs[i] = mls[i] && (my[i] == v_tot(i) - 1);
        if (mls[i]) begin
          mx[i] = 0;
          my[i] = (my[i] == v_tot(i) - 1) ? 0 : my[i] + 1;
        end else begin
          mx[i] = mx[i] + 1;
        end
      end else begin
        mls[i] = 1'b0;
        mfs[i] = 1'b0;
      end
    end
  end

  // Per-presented-position statistics for period and pulse-width checks.
  int line_len [2], de_cnt [2], hlow [2], frame_len [2], vlow [2], line_y [2];
  bit seen_ls [2], seen_fs [2], prev_hs [2], prev_vs [2];

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      if (mvalid[i]) begin
        check($sformatf("u%0d_x", i), x_pos[i], mx[i]);
        check($sformatf("u%0d_y", i), y_pos[i], my[i]);
        check($sformatf("u%0d_hsync", i), hs[i],
              !(mx[i] >= p_ha[i] + p_hf[i] && mx[i] < p_ha[i] + p_hf[i] + p_hs[i]));
        check($sformatf("u%0d_vsync", i), vs[i],
              !(my[i] >= p_va[i] + p_vf[i] && my[i] < p_va[i] + p_vf[i] + p_vs[i]));
        check($sformatf("u%0d_de", i), de[i], (mx[i] < p_ha[i]) && (my[i] < p_va[i]));
        check($sformatf("u%0d_line_start", i), ls[i], mls[i]);
        check($sformatf("u%0d_frame_start", i), fs[i], mfs[i]);
      end
      if (mrst[i]) begin
        line_len[i] = 0; de_cnt[i] = 0; hlow[i] = 0; frame_len[i] = 0; vlow[i] = 0;
        seen_ls[i] = 1'b0; seen_fs[i] = 1'b0; prev_hs[i] = 1'b1; prev_vs[i] = 1'b1;
      end else if (madv[i]) begin
        line_len[i]++;
        frame_len[i]++;
        if (ls[i]) begin
          if (seen_ls[i]) begin
            check($sformatf("u%0d_line_period", i), line_len[i], exp_line[i]);
            check($sformatf("u%0d_de_per_line", i), de_cnt[i],
                  (line_y[i] < p_va[i]) ? exp_de[i] : 0);
          end
          seen_ls[i] = 1'b1;
          line_len[i] = 0;
          de_cnt[i] = 0;
          line_y[i] = y_pos[i];
        end
        if (de[i]) de_cnt[i]++;
        if (!hs[i]) begin
          if (prev_hs[i]) check($sformatf("u%0d_hsync_start_x", i), x_pos[i], exp_hstart[i]);
          hlow[i]++;
        end else if (!prev_hs[i]) begin
          check($sformatf("u%0d_hsync_width", i), hlow[i], exp_hlow[i]);
          hlow[i] = 0;
        end
        prev_hs[i] = hs[i];
        if (!vs[i]) begin
          if (prev_vs[i]) begin
            check($sformatf("u%0d_vsync_start_x", i), x_pos[i], 0);
            check($sformatf("u%0d_vsync_start_y", i), y_pos[i], exp_vstart[i]);
          end
          vlow[i]++;
        end else if (!prev_vs[i]) begin
          check($sformatf("u%0d_vsync_width", i), vlow[i], exp_vlow[i]);
          vlow[i] = 0;
        end
        prev_vs[i] = vs[i];
        if (fs[i]) begin
          if (seen_fs[i]) check($sformatf("u%0d_frame_period", i), frame_len[i], exp_frame[i]);
          seen_fs[i] = 1'b1;
          frame_len[i] = 0;
        end
      end
    end
  end

  task automatic wait_pos(input int i, input int x, input int y, input int budget);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (x_pos[i] == 10'(x) && y_pos[i] == 10'(y)) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL u%0d_wait_pos: (%0d,%0d) not reached in %0d cycles, at (%0d,%0d)",
               i, x, y, budget, x_pos[i], y_pos[i]);
    end
  endtask

  task automatic check_all(input string tag, input int i, input int x, input int y,
                           input bit h, input bit v, input bit d, input bit l, input bit f);
    check({tag, "_x"}, x_pos[i], x);
    check({tag, "_y"}, y_pos[i], y);
    check({tag, "_hsync"}, hs[i], h);
    check({tag, "_vsync"}, vs[i], v);
    check({tag, "_de"}, de[i], d);
    check({tag, "_line_start"}, ls[i], l);
    check({tag, "_frame_start"}, fs[i], f);
  endtask

  task automatic seq_default();
    en[0] = 1'b1;
    repeat (3) @(negedge clk);
    check_all("d_reset", 0, 799, 524, 1, 1, 0, 0, 0);
    rst_n[0] = 1'b1;
    @(posedge clk); #1;
    check_all("d_release", 0, 0, 0, 1, 1, 1, 1, 1);
    wait_pos(0, 655, 1, 3000);
    en[0] = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      check_all("d_frozen", 0, 655, 1, 1, 1, 0, 0, 0);
    end
    @(negedge clk);
    en[0] = 1'b1;
    @(posedge clk); #1;
    check_all("d_resume", 0, 656, 1, 0, 1, 0, 0, 0);
    wait_pos(0, 100, 2, 2000);
  endtask

  task automatic seq_small();
    en[1] = 1'b1;
    repeat (2) @(negedge clk);
    rst_n[1] = 1'b1;
    repeat (350) @(negedge clk);
    wait_pos(1, 14, 5, 200);
    @(posedge clk); #1;
    check_all("s_wrap_active_end", 1, 0, 6, 1, 1, 0, 1, 0);
    wait_pos(1, 14, 10, 200);
    @(posedge clk); #1;
    check_all("s_wrap_frame", 1, 0, 0, 1, 1, 1, 1, 1);
    wait_pos(1, 12, 8, 200);
    check("s_pre_reset_hsync", hs[1], 0);
    check("s_pre_reset_vsync", vs[1], 0);
    rst_n[1] = 1'b0;
    @(posedge clk); #1;
    check_all("s_mid_reset", 1, 14, 10, 1, 1, 0, 0, 0);
    @(negedge clk);
    rst_n[1] = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    rst_n = 2'b00;
    en    = 2'b00;
    fork
      seq_default();
      seq_small();
    join
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete, elapsed=%0t limit=%0d", $time, 1_000_000);
    $fatal(1, "watchdog expired");
  end

endmodule
